// File: rtl/ramb16_s4_ctrl_pkg.sv
// Shared sizes, RAM port bundle and fill FSM state for the RAMB16 S4 port controller.
package ramb16_s4_ctrl_pkg;
   localparam int ADDR_W     = 12;
   localparam int DATA_W     = 4;
   localparam int DEPTH      = 4096;
   localparam int RSPQ_DEPTH = 4;
   localparam int CNT_W      = $clog2(RSPQ_DEPTH + 1);

   typedef enum logic {
      IDLE = 1'b0,
      FILL = 1'b1
   } fill_state_e;

   typedef struct packed {
      logic              en;
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] di;
   } ram_port_t;
endpackage

// File: rtl/ramb16_s4_ctrl_rspq.sv
// In-order read-response queue, RSPQ_DEPTH entries, registered storage and head.
// Latency: pushed data is visible at the head the cycle after the push.
// Backpressure: none internally; the caller's credit rule keeps pushes within capacity.
module ramb16_s4_ctrl_rspq
   import ramb16_s4_ctrl_pkg::*;
(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_dat_i,
   input  logic              pop_i,
   output logic [CNT_W-1:0]  count_o,
   output logic [DATA_W-1:0] head_dat_o
);
   localparam int PTR_W = $clog2(RSPQ_DEPTH);

   logic [DATA_W-1:0] mem_q [RSPQ_DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < RSPQ_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_dat_i;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_i) rd_ptr_q <= rd_ptr_q + 1'b1;
         // A simultaneous push and pop leaves the occupancy unchanged, even when full.
         if (push_i && !pop_i)      count_q <= count_q + 1'b1;
         else if (pop_i && !push_i) count_q <= count_q - 1'b1;
      end
   end

   assign count_o    = count_q;
   assign head_dat_o = mem_q[rd_ptr_q];

   a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && !pop_i && (int'(count_q) == RSPQ_DEPTH)));
   a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      !(pop_i && (count_q == '0)));
endmodule

// File: rtl/ramb16_s4_ctrl.sv
// RAMB16 S4 port controller: request stream to EN/WE/ADDR/DI, in-order read responses; fill engine if RAMB16_S4_CTRL_FILL_EN.
// Latency: read response 2 cycles after accept (empty queue); write commits 1 cycle after accept.
// Backpressure: REQ_READY low while filling or when queued plus in-flight reads reach RSPQ_DEPTH.
module ramb16_s4_ctrl
   import ramb16_s4_ctrl_pkg::*;
#(
   parameter logic [DATA_W-1:0] FILL_VAL = 4'h0
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_vld_i,
   output logic              req_rdy_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_dat_i,
   output logic              rsp_vld_o,
   input  logic              rsp_rdy_i,
   output logic [DATA_W-1:0] rsp_dat_o,
   output logic              ram_en_o,
   output logic              ram_we_o,
   output logic              ram_ssr_o,
   output logic [ADDR_W-1:0] ram_addr_o,
   output logic [DATA_W-1:0] ram_di_o,
   input  logic [DATA_W-1:0] ram_do_i,
   input  logic              fill_start_i,
   output logic              fill_busy_o
);
   ram_port_t         port_q, port_d;
   logic              rd_p1_q, rd_p1_d, rd_p2_q;
   logic [CNT_W-1:0]  q_count;
   logic              credit_ok, req_acc, rsp_pop;
   logic              fill_wr;
   logic [ADDR_W-1:0] fill_addr;

   assign credit_ok = (int'(q_count) + int'(rd_p1_q) + int'(rd_p2_q)) < RSPQ_DEPTH;

`ifdef RAMB16_S4_CTRL_FILL_EN
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   fill_state_e       state_q, state_d;
   logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         fill_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         fill_cnt_q <= fill_cnt_d;
      end
   end

   // fill_cnt_q is the address being written in the current cycle.
   always_comb begin
      state_d    = state_q;
      fill_cnt_d = fill_cnt_q;
      if (state_q == IDLE) begin
         if (fill_start_i) begin
            state_d    = FILL;
            fill_cnt_d = '0;
         end
      end else if (fill_cnt_q == LAST_ADDR) begin
         state_d = IDLE;
      end else begin
         fill_cnt_d = fill_cnt_q + 1'b1;
      end
   end

   assign fill_wr     = (state_d == FILL);
   assign fill_addr   = fill_cnt_d;
   assign fill_busy_o = (state_q == FILL);
   assign req_rdy_o   = !fill_busy_o && !fill_start_i && credit_ok;
`else
   logic unused_fill_start;
   assign unused_fill_start = fill_start_i;
   assign fill_wr           = 1'b0;
   assign fill_addr         = '0;
   assign fill_busy_o       = 1'b0;
   assign req_rdy_o         = credit_ok;
`endif

   assign req_acc = req_vld_i && req_rdy_o;

   always_comb begin
      port_d    = port_q;
      port_d.en = 1'b0;
      port_d.we = 1'b0;
      rd_p1_d   = 1'b0;
      if (req_acc) begin
         port_d  = '{en: 1'b1, we: req_we_i, addr: req_addr_i, di: req_dat_i};
         rd_p1_d = !req_we_i;
      end else if (fill_wr) begin
         port_d  = '{en: 1'b1, we: 1'b1, addr: fill_addr, di: FILL_VAL};
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         port_q  <= '0;
         rd_p1_q <= 1'b0;
         rd_p2_q <= 1'b0;
      end else begin
         port_q  <= port_d;
         rd_p1_q <= rd_p1_d;
         rd_p2_q <= rd_p1_q;
      end
   end

   assign rsp_vld_o = (q_count != '0);
   assign rsp_pop   = rsp_vld_o && rsp_rdy_i;

   ramb16_s4_ctrl_rspq u_rspq (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .push_i     (rd_p2_q),
      .push_dat_i (ram_do_i),
      .pop_i      (rsp_pop),
      .count_o    (q_count),
      .head_dat_o (rsp_dat_o)
   );

   assign ram_en_o   = port_q.en;
   assign ram_we_o   = port_q.we;
   assign ram_ssr_o  = 1'b0;
   assign ram_addr_o = port_q.addr;
   assign ram_di_o   = port_q.di;
endmodule

// File: tb/tb_ramb16_s4_ctrl.sv
// Bench for ramb16_s4_ctrl with a WRITE_FIRST 4096x4 RAM model and a response scoreboard.
module tb_ramb16_s4_ctrl;
   logic        clk = 1'b0;
   logic        rst, req_vld, req_we, rsp_rdy, fill_start;
   logic [11:0] req_addr;
   logic [3:0]  req_dat;
   logic        req_rdy_o, rsp_vld_o, ram_en_o, ram_we_o, ram_ssr_o, fill_busy_o;
   logic [3:0]  rsp_dat_o, ram_di_o, ram_do;
   logic [11:0] ram_addr_o;

   int          checks = 0;
   int          failures = 0;
   logic [3:0]  expq[$];
   logic [3:0]  mem [4096];

   always #5 clk = ~clk;

   ramb16_s4_ctrl #(.FILL_VAL(4'h5)) dut (
      .clk_i(clk), .rst_i(rst),
      .req_vld_i(req_vld), .req_rdy_o(req_rdy_o), .req_we_i(req_we),
      .req_addr_i(req_addr), .req_dat_i(req_dat),
      .rsp_vld_o(rsp_vld_o), .rsp_rdy_i(rsp_rdy), .rsp_dat_o(rsp_dat_o),
      .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_ssr_o(ram_ssr_o),
      .ram_addr_o(ram_addr_o), .ram_di_o(ram_di_o), .ram_do_i(ram_do),
      .fill_start_i(fill_start), .fill_busy_o(fill_busy_o)
   );

   // WRITE_FIRST block RAM model
   always @(posedge clk) begin
      if (ram_en_o) begin
         if (ram_we_o) begin
            mem[ram_addr_o] <= ram_di_o;
            ram_do          <= ram_di_o;
         end else begin
            ram_do <= mem[ram_addr_o];
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every response handshake pops one expected value.
   initial begin
      logic [3:0] e;
      forever begin
         @(negedge clk);
         if (rsp_vld_o && rsp_rdy) begin
            if (expq.size() == 0) begin
               chk("rsp_unexpected", {28'h0, rsp_dat_o}, 32'hFFFF_FFFF);
            end else begin
               e = expq.pop_front();
               chk("rsp_data", {28'h0, rsp_dat_o}, {28'h0, e});
            end
         end
      end
   end

   // Called and returns at posedge+1; leaves the request deasserted.
   task automatic req(input logic we, input logic [11:0] a, input logic [3:0] d, input logic [3:0] exp);
      bit done = 0;
      req_vld = 1'b1; req_we = we; req_addr = a; req_dat = d;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (req_rdy_o) begin
            done = 1;
            if (!we) expq.push_back(exp);
         end
         @(posedge clk); #1;
      end
      req_vld = 1'b0;
      if (!done) chk("req_accept_timeout", 32'(done), 32'd1);
   endtask

   task automatic drain(input string name);
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (expq.size() == 0 && !rsp_vld_o) ok = 1;
      end
      chk(name, 32'(ok), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic fill_pulse();
      fill_start = 1'b1;
      @(posedge clk); #1;
      fill_start = 1'b0;
   endtask

   initial begin
      int   acc;
      time  t0;
      rst = 1'b1; rsp_rdy = 1'b1; fill_start = 1'b0;
      req_vld = 1'b0; req_we = 1'b0; req_addr = '0; req_dat = '0;

      // Reset held two edges with random inputs
      for (int i = 0; i < 2; i++) begin
         req_vld = 1'($urandom_range(0, 1)); req_we = 1'($urandom_range(0, 1));
         req_addr = 12'($urandom); req_dat = 4'($urandom);
         fill_start = 1'($urandom_range(0, 1)); rsp_rdy = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
      end
      rst = 1'b0; req_vld = 1'b0; fill_start = 1'b0; rsp_rdy = 1'b1;
      chk("rst_ram_en", 32'(ram_en_o), 0);
      chk("rst_ram_we", 32'(ram_we_o), 0);
      chk("rst_ram_ssr", 32'(ram_ssr_o), 0);
      chk("rst_ram_addr", 32'(ram_addr_o), 0);
      chk("rst_ram_di", 32'(ram_di_o), 0);
      chk("rst_rsp_vld", 32'(rsp_vld_o), 0);
      chk("rst_rsp_dat", 32'(rsp_dat_o), 0);
      chk("rst_fill_busy", 32'(fill_busy_o), 0);
      chk("rst_req_rdy", 32'(req_rdy_o), 1);

      for (int i = 0; i < 6; i++) req(1'b1, 12'h010 + 12'(i), 4'(i + 1), 4'h0);

      // Read-after-write on the following cycle
      req(1'b1, 12'h123, 4'hA, 4'h0);
      chk("wr_ram_we", 32'(ram_we_o), 1);
      chk("wr_ram_addr", 32'(ram_addr_o), 32'h123);
      chk("wr_ram_di", 32'(ram_di_o), 32'hA);
      req(1'b0, 12'h123, 4'h0, 4'hA);
      chk("rd_ram_en", 32'(ram_en_o), 1);
      chk("rd_ram_we", 32'(ram_we_o), 0);
      @(negedge clk); chk("lat_cyc0_vld", 32'(rsp_vld_o), 0);
      @(negedge clk); chk("lat_cyc1_vld", 32'(rsp_vld_o), 0);
      @(negedge clk); chk("lat_cyc2_vld", 32'(rsp_vld_o), 1);
      @(posedge clk); #1;
      drain("raw_drain");
      chk("idle_ram_en", 32'(ram_en_o), 0);
      chk("idle_ram_addr_hold", 32'(ram_addr_o), 32'h123);

      // Back-pressure: six back-to-back reads with the consumer stalled
      rsp_rdy = 1'b0; acc = 0;
      for (int i = 0; i < 6; i++) begin
         req_vld = 1'b1; req_we = 1'b0; req_addr = 12'h010 + 12'(acc);
         @(negedge clk);
         if (req_rdy_o) begin
            expq.push_back(4'(acc + 1));
            acc++;
         end
         @(posedge clk); #1;
      end
      req_vld = 1'b0;
      chk("bp_accepted", 32'(acc), 4);
      chk("bp_req_rdy_low", 32'(req_rdy_o), 0);
      chk("bp_rsp_vld", 32'(rsp_vld_o), 1);
      rsp_rdy = 1'b1;
      req(1'b0, 12'h014, 4'h0, 4'h5);
      req(1'b0, 12'h015, 4'h0, 4'h6);
      drain("bp_drain");

      // Push and pop in the same cycle with the queue near full
      rsp_rdy = 1'b0;
      for (int i = 0; i < 4; i++) req(1'b0, 12'h010 + 12'(i), 4'h0, 4'(i + 1));
      @(posedge clk); #1;
      rsp_rdy = 1'b1;
      @(posedge clk); #1;
      rsp_rdy = 1'b0;
      @(negedge clk);
      chk("pushpop_req_rdy", 32'(req_rdy_o), 1);
      chk("pushpop_rsp_vld", 32'(rsp_vld_o), 1);
      @(posedge clk); #1;
      rsp_rdy = 1'b1;
      drain("pushpop_drain");

      // Sustained one request per cycle
      t0 = $time;
      for (int i = 0; i < 6; i++) req(1'b0, 12'h010 + 12'(i), 4'h0, 4'(i + 1));
      chk("throughput_cycles", 32'(($time - t0) / 10), 6);
      drain("tput_drain");

`ifdef RAMB16_S4_CTRL_FILL_EN
      begin
         int          busy_cnt = 0;
         int          rdy_bad = 0;
         logic [11:0] last_addr = '0;
         bit          ended = 0;
         fill_pulse();
         chk("fill_busy_start", 32'(fill_busy_o), 1);
         chk("fill_first_addr", 32'(ram_addr_o), 0);
         chk("fill_first_di", 32'(ram_di_o), 5);
         for (int i = 0; i < 5000 && !ended; i++) begin
            @(negedge clk);
            fill_start = (busy_cnt == 10);
            if (!fill_busy_o) begin
               ended = 1;
            end else begin
               busy_cnt++;
               last_addr = ram_addr_o;
               if (req_rdy_o || !ram_we_o) rdy_bad++;
            end
         end
         fill_start = 1'b0;
         chk("fill_busy_cycles", 32'(busy_cnt), 4096);
         chk("fill_rdy_or_we_bad", 32'(rdy_bad), 0);
         chk("fill_last_addr", 32'(last_addr), 32'hFFF);
         chk("fill_end_req_rdy", 32'(req_rdy_o), 1);
         @(posedge clk); #1;
      end
      req(1'b0, 12'h000, 4'h0, 4'h5);
      req(1'b0, 12'h7FF, 4'h0, 4'h5);
      req(1'b0, 12'hFFF, 4'h0, 4'h5);
      drain("fill_drain");

      // Reset at fill cycle 100
      req(1'b1, 12'h063, 4'hC, 4'h0);
      req(1'b1, 12'h064, 4'hC, 4'h0);
      fill_pulse();
      repeat (99) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstfill_busy", 32'(fill_busy_o), 0);
      chk("rstfill_ram_we", 32'(ram_we_o), 0);
      chk("rstfill_req_rdy", 32'(req_rdy_o), 1);
      req(1'b0, 12'h063, 4'h0, 4'h5);
      req(1'b0, 12'h064, 4'h0, 4'hC);
      drain("rstfill_drain");
`else
      fill_start = 1'b1;
      @(negedge clk);
      chk("nofill_req_rdy", 32'(req_rdy_o), 1);
      @(posedge clk); #1;
      fill_start = 1'b0;
      chk("nofill_busy", 32'(fill_busy_o), 0);
      chk("nofill_ram_en", 32'(ram_en_o), 0);
      req(1'b0, 12'h123, 4'h0, 4'hA);
      drain("nofill_drain");
`endif

      chk("scoreboard_empty", 32'(expq.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
